// File: rtl/fadd_accum_seq.sv
// rtl/fadd_accum_seq.sv - packet accumulator sequencing an external FloatAdd stage
module fadd_accum_seq #(
  parameter int XLEN    = 32,
  parameter int CNT_W   = 16,
  parameter int ADD_LAT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [XLEN-1:0]  in_data,
  input  logic             in_valid,
  input  logic             in_last,
  output logic             in_ready,
  output logic [XLEN-1:0]  add_a,
  output logic [XLEN-1:0]  add_b,
  input  logic [XLEN-1:0]  add_result,
  input  logic             add_overflow,
  input  logic             add_underflow,
  input  logic             add_exception,
  output logic [XLEN-1:0]  out_sum,
  output logic [CNT_W-1:0] out_count,
  output logic [2:0]       out_flags,
  output logic             out_valid,
  input  logic             out_ready
);

  // Wait counter must hold the value ADD_LAT; keep it at least one bit wide.
  localparam int WC_W = (ADD_LAT < 2) ? 1 : $clog2(ADD_LAT + 1);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_ACC      = 2'd1,
    S_ADD_WAIT = 2'd2,
    S_DONE     = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_next_state;

  logic [XLEN-1:0]  r_acc;
  logic [XLEN-1:0]  r_add_b;
  logic             r_pend_last;
  logic [WC_W-1:0]  r_wait_cnt;
  logic [CNT_W-1:0] r_count;
  logic [2:0]       r_flags;
  logic [XLEN-1:0]  r_out_sum;
  logic [CNT_W-1:0] r_out_count;
  logic [2:0]       r_out_flags;

  logic             w_accept;
  logic             w_in_zero;
  logic             w_acc_zero;
  logic             w_add_done;
  logic             w_load_b;
  logic             w_enter_done;
  logic [CNT_W-1:0] w_count_inc;
  logic [XLEN-1:0]  w_acc_nxt;
  logic [CNT_W-1:0] w_count_nxt;
  logic [2:0]       w_flags_nxt;

  assign in_ready   = (r_state == S_IDLE) || (r_state == S_ACC);
  assign out_valid  = (r_state == S_DONE);
  assign w_accept   = in_valid && in_ready;

  // Zero of either sign: FloatAdd has no zero handling, so zeros bypass it.
  assign w_in_zero  = (in_data[XLEN-2:0] == '0);
  assign w_acc_zero = (r_acc[XLEN-2:0] == '0);

  // The add result is sampled on the last edge of the wait window.
  assign w_add_done = (r_state == S_ADD_WAIT) && (r_wait_cnt == WC_W'(1));

  // Operand count saturates instead of wrapping; summing continues regardless.
  assign w_count_inc = (&r_count) ? r_count : r_count + CNT_W'(1);

  assign w_enter_done = (w_next_state == S_DONE) && (r_state != S_DONE);

  // Next-state and next accumulator/count/flags selection.
  always_comb begin
    w_next_state = r_state;
    w_acc_nxt    = r_acc;
    w_count_nxt  = r_count;
    w_flags_nxt  = r_flags;
    w_load_b     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_acc_nxt    = in_data;
          w_count_nxt  = CNT_W'(1);
          w_flags_nxt  = 3'b000;
          w_next_state = in_last ? S_DONE : S_ACC;
        end
      end
      S_ACC: begin
        if (w_accept) begin
          w_count_nxt = w_count_inc;
          if (w_in_zero) begin
            w_next_state = in_last ? S_DONE : S_ACC;
          end else if (w_acc_zero) begin
            w_acc_nxt    = in_data;
            w_next_state = in_last ? S_DONE : S_ACC;
          end else begin
            w_load_b     = 1'b1;
            w_next_state = S_ADD_WAIT;
          end
        end
      end
      S_ADD_WAIT: begin
        if (w_add_done) begin
          w_acc_nxt    = add_result;
          w_flags_nxt  = r_flags | {add_exception, add_underflow, add_overflow};
          w_next_state = r_pend_last ? S_DONE : S_ACC;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          w_next_state = S_IDLE;
        end
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Accumulator, count, sticky flags and the pending FloatAdd operand.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc       <= '0;
      r_count     <= '0;
      r_flags     <= 3'b000;
      r_add_b     <= '0;
      r_pend_last <= 1'b0;
      r_wait_cnt  <= '0;
    end else begin
      r_acc   <= w_acc_nxt;
      r_count <= w_count_nxt;
      r_flags <= w_flags_nxt;
      if (w_load_b) begin
        r_add_b     <= in_data;
        r_pend_last <= in_last;
        r_wait_cnt  <= WC_W'(ADD_LAT);
      end else if ((r_state == S_ADD_WAIT) && !w_add_done) begin
        r_wait_cnt <= r_wait_cnt - WC_W'(1);
      end
    end
  end

  // Result registers are captured once, on the edge that enters DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_sum   <= '0;
      r_out_count <= '0;
      r_out_flags <= 3'b000;
    end else if (w_enter_done) begin
      r_out_sum   <= w_acc_nxt;
      r_out_count <= w_count_nxt;
      r_out_flags <= w_flags_nxt;
    end
  end

  assign add_a     = r_acc;
  assign add_b     = r_add_b;
  assign out_sum   = r_out_sum;
  assign out_count = r_out_count;
  assign out_flags = r_out_flags;

endmodule

// File: tb/tb_fadd_accum_seq.sv
// tb/tb_fadd_accum_seq.sv - directed self-checking bench for fadd_accum_seq
module tb_fadd_accum_seq;

  localparam int XLEN    = 32;
  localparam int CNT_W   = 4;
  localparam int ADD_LAT = 1;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [XLEN-1:0]  in_data = '0;
  logic             in_valid = 1'b0;
  logic             in_last = 1'b0;
  logic             in_ready;
  logic [XLEN-1:0]  add_a;
  logic [XLEN-1:0]  add_b;
  logic [XLEN-1:0]  add_result;
  logic             add_overflow;
  logic             add_underflow;
  logic             add_exception;
  logic [XLEN-1:0]  out_sum;
  logic [CNT_W-1:0] out_count;
  logic [2:0]       out_flags;
  logic             out_valid;
  logic             out_ready = 1'b0;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  fadd_accum_seq #(.XLEN(XLEN), .CNT_W(CNT_W), .ADD_LAT(ADD_LAT)) dut (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
    .add_a(add_a), .add_b(add_b), .add_result(add_result),
    .add_overflow(add_overflow), .add_underflow(add_underflow), .add_exception(add_exception),
    .out_sum(out_sum), .out_count(out_count), .out_flags(out_flags),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // FloatAdd stand-in: table of the exact sums used by the vectors below.
  always_comb begin
    add_result    = 32'hDEADBEEF;
    add_overflow  = 1'b0;
    add_underflow = 1'b0;
    add_exception = 1'b0;
    case ({add_a, add_b})
      {32'h3F800000, 32'h40000000}: add_result = 32'h40400000;
      {32'h40400000, 32'h3FC00000}: add_result = 32'h40900000;
      {32'h7F000000, 32'h7F000000}: begin add_result = 32'h7F800000; add_overflow = 1'b1; end
      {32'h40000000, 32'h7F800000}: begin add_result = 32'h7F800000; add_exception = 1'b1; end
      default: add_result = 32'hDEADBEEF;
    endcase
  end

  task automatic send(input logic [31:0] d, input logic l);
    int  guard;
    logic took;
    guard = 0;
    took  = 1'b0;
    in_data  = d;
    in_valid = 1'b1;
    in_last  = l;
    do begin
      took = in_ready;
      @(posedge clk); #1;
      guard++;
    end while (!took && guard < 50);
    in_valid = 1'b0;
    in_last  = 1'b0;
    tests++;
    if (!took) begin
      fails++;
      $display("FAIL send_timeout data=%h accepted=%b want 1", d, took);
    end
  endtask

  task automatic wait_out(input string name);
    int n;
    n = 0;
    while (out_valid !== 1'b1 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    tests++;
    if (out_valid !== 1'b1) begin
      fails++;
      $display("FAIL %s_timeout out_valid=%b want 1", name, out_valid);
    end
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    #3;
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL rst_out_valid got %b want 0", out_valid); end
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL rst_in_ready got %b want 1", in_ready); end
    tests++; if (out_sum !== 32'h0) begin fails++; $display("FAIL rst_out_sum got %h want 0", out_sum); end
    tests++; if (out_count !== 4'd0) begin fails++; $display("FAIL rst_out_count got %0d want 0", out_count); end
    tests++; if (out_flags !== 3'b000) begin fails++; $display("FAIL rst_out_flags got %b want 000", out_flags); end
    tests++; if (add_a !== 32'h0 || add_b !== 32'h0) begin fails++; $display("FAIL rst_add_ab got %h/%h want 0/0", add_a, add_b); end
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_basic_sum();
    int t0;
    send(32'h3F800000, 1'b0);
    t0 = cyc;
    send(32'h40000000, 1'b0);
    send(32'h3FC00000, 1'b1);
    wait_out("basic");
    // Fifth cycle counting the accept cycle: four edges after the first accept edge.
    tests++; if (cyc - t0 !== 4) begin fails++; $display("FAIL basic_latency got %0d edges want 4", cyc - t0); end
    tests++; if (out_sum !== 32'h40900000) begin fails++; $display("FAIL basic_sum got %h want 40900000", out_sum); end
    tests++; if (out_count !== 4'd3) begin fails++; $display("FAIL basic_count got %0d want 3", out_count); end
    tests++; if (out_flags !== 3'b000) begin fails++; $display("FAIL basic_flags got %b want 000", out_flags); end
    tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL basic_in_ready_done got %b want 0", in_ready); end
    release_out();
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL basic_release got %b want 0", out_valid); end
  endtask

  task automatic test_single();
    send(32'h40400000, 1'b1);
    tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL single_valid got %b want 1", out_valid); end
    tests++; if (out_sum !== 32'h40400000) begin fails++; $display("FAIL single_sum got %h want 40400000", out_sum); end
    tests++; if (out_count !== 4'd1) begin fails++; $display("FAIL single_count got %0d want 1", out_count); end
    release_out();
  endtask

  task automatic test_zeros();
    logic rdy_ok;
    rdy_ok = 1'b1;
    if (in_ready !== 1'b1) rdy_ok = 1'b0;
    send(32'h00000000, 1'b0);
    if (in_ready !== 1'b1) rdy_ok = 1'b0;
    send(32'h40000000, 1'b0);
    if (in_ready !== 1'b1) rdy_ok = 1'b0;
    send(32'h80000000, 1'b1);
    tests++; if (rdy_ok !== 1'b1) begin fails++; $display("FAIL zeros_in_ready got %b want 1", rdy_ok); end
    tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL zeros_valid got %b want 1", out_valid); end
    tests++; if (out_sum !== 32'h40000000) begin fails++; $display("FAIL zeros_sum got %h want 40000000", out_sum); end
    tests++; if (out_count !== 4'd3) begin fails++; $display("FAIL zeros_count got %0d want 3", out_count); end
    // add_b still holds the operand loaded by the basic packet.
    tests++; if (add_b !== 32'h3FC00000) begin fails++; $display("FAIL zeros_add_b got %h want 3FC00000", add_b); end
    release_out();
  endtask

  task automatic test_flags();
    send(32'h7F000000, 1'b0);
    send(32'h7F000000, 1'b1);
    tests++; if (add_a !== 32'h7F000000 || add_b !== 32'h7F000000) begin fails++; $display("FAIL ovf_operands got %h/%h want 7F000000/7F000000", add_a, add_b); end
    wait_out("ovf");
    tests++; if (out_flags !== 3'b001) begin fails++; $display("FAIL ovf_flags got %b want 001", out_flags); end
    tests++; if (out_sum !== 32'h7F800000) begin fails++; $display("FAIL ovf_sum got %h want 7F800000", out_sum); end
    release_out();
    send(32'h40000000, 1'b0);
    send(32'h7F800000, 1'b1);
    wait_out("exc");
    tests++; if (out_flags !== 3'b100) begin fails++; $display("FAIL exc_flags got %b want 100", out_flags); end
    release_out();
    send(32'h3F800000, 1'b1);
    tests++; if (out_flags !== 3'b000) begin fails++; $display("FAIL clear_flags got %b want 000", out_flags); end
    release_out();
  endtask

  task automatic test_hold();
    int bad;
    bad = 0;
    send(32'h3F800000, 1'b0);
    send(32'h40000000, 1'b1);
    wait_out("hold");
    in_data  = 32'h12345678;
    in_valid = 1'b1;
    in_last  = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_sum !== 32'h40400000 ||
          out_count !== 4'd2 || out_flags !== 3'b000) bad++;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    tests++; if (bad !== 0) begin fails++; $display("FAIL hold_stable got %0d unstable cycles want 0", bad); end
    release_out();
    tests++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin fails++; $display("FAIL hold_release got valid=%b ready=%b want 0/1", out_valid, in_ready); end
    tests++; if (out_sum !== 32'h40400000) begin fails++; $display("FAIL hold_sum_kept got %h want 40400000", out_sum); end
  endtask

  task automatic test_reset_mid();
    int seen;
    seen = 0;
    send(32'h3F800000, 1'b0);
    send(32'h40000000, 1'b0);
    tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL mid_in_wait got in_ready=%b want 0", in_ready); end
    rst = 1'b1;
    #2;
    tests++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || add_a !== 32'h0) begin
      fails++; $display("FAIL mid_rst got valid=%b ready=%b acc=%h want 0/1/0", out_valid, in_ready, add_a);
    end
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b0) seen++;
    end
    tests++; if (seen !== 0) begin fails++; $display("FAIL mid_no_valid got %0d valid cycles want 0", seen); end
    send(32'h3F800000, 1'b1);
    tests++; if (out_sum !== 32'h3F800000 || out_count !== 4'd1) begin
      fails++; $display("FAIL mid_next got sum=%h count=%0d want 3F800000/1", out_sum, out_count);
    end
    release_out();
  endtask

  task automatic test_saturate();
    send(32'h3F800000, 1'b0);
    for (int i = 0; i < 18; i++) send(32'h00000000, 1'b0);
    send(32'h40000000, 1'b1);
    wait_out("sat");
    tests++; if (out_count !== 4'd15) begin fails++; $display("FAIL sat_count got %0d want 15", out_count); end
    tests++; if (out_sum !== 32'h40400000) begin fails++; $display("FAIL sat_sum got %h want 40400000", out_sum); end
    release_out();
  endtask

  initial begin
    test_reset();
    test_basic_sum();
    test_single();
    test_zeros();
    test_flags();
    test_hold();
    test_reset_mid();
    test_saturate();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
